gpio_in_filter: RTL and testbench
=================================

// Module: gpio_in_filter
// PURPOSE
//  Per-pin input conditioner between padctl cio_gpio_p2d and top_tetley mio_in_i.
//  - Synchronises asynchronous board GPIO inputs into clk_sys.
//  - Debounces each pin with a consecutive-stable counter, so switch/button bounce never reaches the GPIO block.
//  - Per-pin enable selects filtered or synchronised-only path.
// PARAMETERS
//  NumPins        32    number of GPIO inputs filtered
//  SyncStages     2     synchroniser flops per pin (>=2)
//  DebounceCycles 4     consecutive differing samples needed to accept a new level (>=1)
//  ResetVal       '0    NumPins-bit reset value of sync chain, stable state and pin_o
// PORTS
//  clk_i    in   1        system clock (clk_sys)
//  rst_ni   in   1        asynchronous active-low reset (rst_sys_n)
//  pin_i    in   NumPins  raw pad inputs (async to clk_i)
//  en_i     in   NumPins  1 = debounce pin, 0 = synchronise only
//  pin_o    out  NumPins  conditioned inputs to mio_in_i
//  rise_o   out  NumPins  one-cycle pulse on pin_o 0->1 (GPIO_FILT_EDGE_EVENT_EN only)
//  fall_o   out  NumPins  one-cycle pulse on pin_o 1->0 (GPIO_FILT_EDGE_EVENT_EN only)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low; no other clocks or resets.
//  - Reset: sync chain = ResetVal, stable_q = ResetVal, cnt_q = 0, pin_o = ResetVal, rise_o/fall_o = 0.
//  - Sync: pin_i passes through SyncStages flops -> sync[i]. No logic between stages.
//  - Per pin, registered stable_q and cnt_q, width $clog2(DebounceCycles) (min 1 bit).
//  - Each edge with en_i=1:
//    - sync != stable_q and cnt_q == DebounceCycles-1: stable_q <= sync, cnt_q <= 0.
//    - sync != stable_q otherwise: cnt_q <= cnt_q + 1.
//    - sync == stable_q: cnt_q <= 0. Any return to the old level restarts the count.
//  - Each edge with en_i=0: stable_q <= sync, cnt_q <= 0.
//  - pin_o = en_i ? stable_q : sync, combinational from flops only.
//  - Latency from pin_i change sampled at edge 1:
//    - en=1: pin_o changes after edge SyncStages+DebounceCycles.
//    - en=0: pin_o changes after edge SyncStages.
//  - Glitch rejection: pulses shorter than DebounceCycles sampled cycles never reach pin_o when en=1.
//  - cnt_q never exceeds DebounceCycles-1 and never wraps.
//  - DebounceCycles=1: accept on first differing sample.
//  - en_i toggling mid-count: 1->0 clears cnt_q; pin_o switches to sync in the same cycle.
//    0->1: stable_q already equals sync, so pin_o does not glitch.
//  - Reset mid-count: all state returns to reset values. No partial count survives.
// CONFIGURATION
//  - `GPIO_FILT_EDGE_EVENT_EN defined:
//    - rise_o/fall_o ports exist.
//    - pin_q holds pin_o delayed 1 cycle.
//    - rise_o = pin_o & ~pin_q; fall_o = ~pin_o & pin_q.
//    - pin_q resets to ResetVal, so there is no pulse out of reset.
//  - Not defined: rise_o/fall_o ports and pin_q are absent. pin_o behaviour is identical.
// STRUCTURE
//  - gpio_filt_pkg:
//    - localparam function cnt_width(DebounceCycles).
//    - typedef gpio_vec_t (logic [NumPins-1:0]).
//    - default constants GpioFiltSyncStages=2, GpioFiltDebounce=4.
//  - Sub-module gpio_filter_pin: one pin's sync chain, cnt_q, stable_q and output mux.
//    Top level generates NumPins instances plus optional edge logic.
// TESTING (NumPins=4, SyncStages=2, DebounceCycles=4, ResetVal=0 unless noted)
//  1. Reset, pin_i=4'hF held -> pin_o=0 until edge 6, pin_o=4'hF after edge 6, stays.
//  2. en_i=1, pin_i[0] high for 3 cycles then low -> pin_o[0] stays 0 throughout.
//  3. en_i=1, pin_i[1] bounces 1,0,1,1,0,1,1,1,1 per cycle -> pin_o[1] rises exactly 6 edges after the final 0->1.
//  4. en_i=0, pin_i[2] 1-cycle pulse -> pin_o[2] 1-cycle pulse after edge 2.
//     Set en_i[2]=1 mid-count -> no glitch on pin_o[2].
//  5. rst_ni asserted async with cnt_q=3 -> pin_o=0 immediately.
//     After release, a differing level needs the full 4 samples again.
//  6. GPIO_FILT_EDGE_EVENT_EN, ResetVal=4'hF: no pulse after reset.
//     pin_i[3] 1->0 held -> fall_o[3] single pulse coincident with pin_o[3] falling; rise_o stays 0.

Source files
------------

// File: rtl/gpio_filt_pkg.sv
// Shared constants, types and sizing helper for the GPIO input filter.
// Consumed by gpio_filter_pin and gpio_in_filter.
package gpio_filt_pkg;

  localparam int GpioFiltNumPins    = 32;
  localparam int GpioFiltSyncStages = 2;
  localparam int GpioFiltDebounce   = 4;

  typedef logic [GpioFiltNumPins-1:0] gpio_vec_t;

  // Counter only has to reach DebounceCycles-1; keep at least one bit.
  function automatic int cnt_width(input int debounce_cycles);
    return (debounce_cycles <= 2) ? 1 : $clog2(debounce_cycles);
  endfunction

endpackage

// File: rtl/gpio_filter_pin.sv
// One GPIO pin: synchroniser chain, consecutive-stable debounce counter
// and the filtered/synchronised-only output select.
module gpio_filter_pin
  import gpio_filt_pkg::*;
#(
  parameter int   SyncStages     = GpioFiltSyncStages,
  parameter int   DebounceCycles = GpioFiltDebounce,
  parameter logic ResetVal       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  input  logic en_i,
  output logic pin_o
);

  localparam int              CntW   = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  sync;
  logic                  stable_q, stable_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SyncStages{ResetVal}};
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pin_i};
    end
  end

  assign sync = sync_q[SyncStages-1];

  // Any sample matching the held level clears the count, so only an
  // unbroken run of DebounceCycles differing samples is accepted.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (!en_i) begin
      stable_d = sync;
    end else if (sync != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= ResetVal;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pin_o = en_i ? stable_q : sync;

endmodule

// File: rtl/gpio_in_filter.sv
// Per-pin GPIO input conditioner: sync + debounce for NumPins pads.
// Optional rise/fall event pulses when GPIO_FILT_EDGE_EVENT_EN is defined.
module gpio_in_filter
  import gpio_filt_pkg::*;
#(
  parameter int                 NumPins        = GpioFiltNumPins,
  parameter int                 SyncStages     = GpioFiltSyncStages,
  parameter int                 DebounceCycles = GpioFiltDebounce,
  parameter logic [NumPins-1:0] ResetVal       = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumPins-1:0] pin_i,
  input  logic [NumPins-1:0] en_i,
  output logic [NumPins-1:0] pin_o
`ifdef GPIO_FILT_EDGE_EVENT_EN
  ,
  output logic [NumPins-1:0] rise_o,
  output logic [NumPins-1:0] fall_o
`endif
);

  for (genvar g = 0; g < NumPins; g++) begin : g_pin
    gpio_filter_pin #(
      .SyncStages     (SyncStages),
      .DebounceCycles (DebounceCycles),
      .ResetVal       (ResetVal[g])
    ) u_pin (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .pin_i  (pin_i[g]),
      .en_i   (en_i[g]),
      .pin_o  (pin_o[g])
    );
  end

`ifdef GPIO_FILT_EDGE_EVENT_EN
  logic [NumPins-1:0] pin_q;

  // Reset to ResetVal so leaving reset never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pin_q <= ResetVal;
    end else begin
      pin_q <= pin_o;
    end
  end

  assign rise_o = pin_o & ~pin_q;
  assign fall_o = ~pin_o & pin_q;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter (NumPins=4, SyncStages=2, DebounceCycles=4).
// Edge-event checks are included when GPIO_FILT_EDGE_EVENT_EN is defined.
module tb_gpio_in_filter;

  localparam int NP = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NP-1:0] pin_i;
  logic [NP-1:0] en_i;
  logic [NP-1:0] pin_o;
  logic [NP-1:0] pin_o_f;
`ifdef GPIO_FILT_EDGE_EVENT_EN
  logic [NP-1:0] rise_o, fall_o, rise_o_f, fall_o_f;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  gpio_in_filter #(
    .NumPins(NP), .SyncStages(2), .DebounceCycles(4), .ResetVal(4'h0)
  ) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .pin_i  (pin_i),
    .en_i   (en_i),
    .pin_o  (pin_o)
`ifdef GPIO_FILT_EDGE_EVENT_EN
    ,
    .rise_o (rise_o),
    .fall_o (fall_o)
`endif
  );

  gpio_in_filter #(
    .NumPins(NP), .SyncStages(2), .DebounceCycles(4), .ResetVal(4'hF)
  ) u_dut_f (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .pin_i  (pin_i),
    .en_i   (en_i),
    .pin_o  (pin_o_f)
`ifdef GPIO_FILT_EDGE_EVENT_EN
    ,
    .rise_o (rise_o_f),
    .fall_o (fall_o_f)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic [NP-1:0] pin_v);
    #2;
    rst_ni = 1'b0;
    pin_i  = pin_v;
    repeat (3) tick();
    rst_ni = 1'b1;
  endtask

  logic [8:0] bounce;

  initial begin
    rst_ni = 1'b0;
    pin_i  = '0;
    en_i   = 4'hF;

    // 1: pin_i = F held across reset release; accepted after edge 6
    do_reset(4'hF);
    check("t1_reset", 32'(pin_o), 32'h0);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("t1_edge%0d", e), 32'(pin_o), (e < 6) ? 32'h0 : 32'hF);
`ifdef GPIO_FILT_EDGE_EVENT_EN
      check($sformatf("t1_rise%0d", e), 32'(rise_o), (e == 6) ? 32'hF : 32'h0);
`endif
    end

    // 2: 3-cycle high pulse on pin 0 is rejected
    do_reset(4'h0);
    pin_i = 4'h1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) pin_i = 4'h0;
      check($sformatf("t2_edge%0d", e), 32'(pin_o[0]), 32'h0);
    end

    // 3: bounce on pin 1; final 0->1 sampled at edge 6, accepted at edge 11
    do_reset(4'h0);
    bounce = 9'b1_1110_1101;
    for (int e = 1; e <= 13; e++) begin
      pin_i[1] = (e <= 9) ? bounce[e-1] : 1'b1;
      tick();
      check($sformatf("t3_edge%0d", e), 32'(pin_o[1]), (e < 11) ? 32'h0 : 32'h1);
    end

    // 4a: sync-only pin 2, single-cycle pulse passes through after edge 2
    en_i = 4'b1011;
    do_reset(4'h0);
    pin_i[2] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      pin_i[2] = 1'b0;
      check($sformatf("t4a_edge%0d", e), 32'(pin_o[2]), (e == 2) ? 32'h1 : 32'h0);
    end
    // 4b: enabling the filter while tracking must not glitch
    pin_i[2] = 1'b1;
    repeat (3) tick();
    check("t4b_before_en", 32'(pin_o[2]), 32'h1);
    en_i[2] = 1'b1;
    #1;
    check("t4b_at_en", 32'(pin_o[2]), 32'h1);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("t4b_edge%0d", e), 32'(pin_o[2]), 32'h1);
    end
    // 4c: disabling mid-count shows the synchronised level immediately
    pin_i[2] = 1'b0;
    repeat (4) tick();
    check("t4c_counting", 32'(pin_o[2]), 32'h1);
    en_i[2] = 1'b0;
    #1;
    check("t4c_at_dis", 32'(pin_o[2]), 32'h0);
    en_i = 4'hF;

    // 5: async reset mid-count, then full count needed again
    do_reset(4'h0);
    pin_i = 4'hF;
    repeat (6) tick();
    check("t5_settled", 32'(pin_o), 32'hF);
    pin_i = 4'h0;
    repeat (5) tick();
    check("t5_cnt3", 32'(pin_o), 32'hF);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t5_async", 32'(pin_o), 32'h0);
    pin_i = 4'hF;
    repeat (2) tick();
    rst_ni = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("t5_edge%0d", e), 32'(pin_o), (e < 6) ? 32'h0 : 32'hF);
    end

    // 6: ResetVal = F instance; no event out of reset, pin 3 falls after edge 6
    do_reset(4'hF);
    check("t6_reset", 32'(pin_o_f), 32'hF);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("t6_idle%0d", e), 32'(pin_o_f), 32'hF);
`ifdef GPIO_FILT_EDGE_EVENT_EN
      check($sformatf("t6_idle_rise%0d", e), 32'(rise_o_f), 32'h0);
      check($sformatf("t6_idle_fall%0d", e), 32'(fall_o_f), 32'h0);
`endif
    end
    pin_i[3] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("t6_edge%0d", e), 32'(pin_o_f), (e < 6) ? 32'hF : 32'h7);
`ifdef GPIO_FILT_EDGE_EVENT_EN
      check($sformatf("t6_fall%0d", e), 32'(fall_o_f), (e == 6) ? 32'h8 : 32'h0);
      check($sformatf("t6_rise%0d", e), 32'(rise_o_f), 32'h0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
